// File: rtl/ps2_hex_entry.sv
// PS/2 keyboard receiver with a 4-digit hex entry decoder.
// Digits shift in from the right; Backspace, Escape and Enter edit or commit the value.
module ps2_hex_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] number,
  output logic        number_valid,
  output logic [2:0]  digit_count,
  output logic        frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DONE = 2'd2} state_t;

  // Returns {hit, nibble} for a make code that maps to a hex digit.
  function automatic logic [4:0] hex_code(input logic [7:0] b);
    case (b)
      8'h45: hex_code = 5'h10;  8'h16: hex_code = 5'h11;
      8'h1E: hex_code = 5'h12;  8'h26: hex_code = 5'h13;
      8'h25: hex_code = 5'h14;  8'h2E: hex_code = 5'h15;
      8'h36: hex_code = 5'h16;  8'h3D: hex_code = 5'h17;
      8'h3E: hex_code = 5'h18;  8'h46: hex_code = 5'h19;
      8'h1C: hex_code = 5'h1A;  8'h32: hex_code = 5'h1B;
      8'h21: hex_code = 5'h1C;  8'h23: hex_code = 5'h1D;
      8'h24: hex_code = 5'h1E;  8'h2B: hex_code = 5'h1F;
      default: hex_code = 5'h00;
    endcase
  endfunction

  // Frame = {stop, parity, data[7:0]}; good when stop is high and parity is odd.
  function automatic logic frame_ok(input logic [9:0] f);
    frame_ok = f[9] & (^f[8:0]);
  endfunction

  logic          clk_meta_q, clk_sync_q, clk_prev_q, dat_meta_q, dat_sync_q;
  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [9:0]    shift_q, shift_d;
  logic [15:0]   number_q, number_d;
  logic [2:0]    count_q, count_d;
  logic          brk_q, brk_d, fresh_q, fresh_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic          fall_s, deliver_s;
  logic [7:0]    byte_s;
  logic [4:0]    dig_s;

  assign fall_s    = clk_prev_q & ~clk_sync_q;
  assign byte_s    = shift_q[7:0];
  assign deliver_s = (state_q == DONE) && frame_ok(shift_q);
  assign dig_s     = hex_code(byte_s);

  // Receiver: start-bit hunt, 10 sampled bits, frame check, inter-edge timeout.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    shift_d = shift_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_s && !dat_sync_q) begin
          state_d = RECV;
          idx_d   = 4'd0;
          tmo_d   = '0;
        end else begin
        end
      end
      RECV: begin
        if (fall_s) begin
          shift_d = {dat_sync_q, shift_q[9:1]};
          tmo_d   = '0;
          if (idx_q == 4'd9) begin
            state_d = DONE;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
          idx_d   = 4'd0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = ~frame_ok(shift_q);
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoder: break/extended prefixes, digit entry and edit keys.
  always_comb begin
    number_d = number_q;
    count_d  = count_q;
    brk_d    = brk_q;
    fresh_d  = fresh_q;
    valid_d  = 1'b0;
    if (deliver_s) begin
      if (byte_s == 8'hE0) begin
      end else if (byte_s == 8'hF0) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        brk_d = 1'b0;
      end else if (dig_s[4]) begin
        if (fresh_q) begin
          number_d = {12'h000, dig_s[3:0]};
          count_d  = 3'd1;
          fresh_d  = 1'b0;
        end else if (count_q < 3'd4) begin
          number_d = {number_q[11:0], dig_s[3:0]};
          count_d  = count_q + 3'd1;
        end else begin
        end
      end else begin
        case (byte_s)
          8'h66: begin
            fresh_d = 1'b0;
            if (count_q != 3'd0) begin
              number_d = {4'h0, number_q[15:4]};
              count_d  = count_q - 3'd1;
            end else begin
            end
          end
          8'h76: begin
            number_d = 16'h0000;
            count_d  = 3'd0;
            fresh_d  = 1'b0;
          end
          8'h5A: begin
            valid_d = 1'b1;
            fresh_d = 1'b1;
          end
          default: begin
          end
        endcase
      end
    end else begin
    end
  end

  // Synchronizers idle high so release from reset never fakes a falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      tmo_q      <= '0;
      shift_q    <= 10'h000;
      number_q   <= 16'h0000;
      count_q    <= 3'd0;
      brk_q      <= 1'b0;
      fresh_q    <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      shift_q    <= shift_d;
      number_q   <= number_d;
      count_q    <= count_d;
      brk_q      <= brk_d;
      fresh_q    <= fresh_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign number       = number_q;
  assign digit_count  = count_q;
  assign number_valid = valid_q;
  assign frame_err    = err_q;

endmodule
